// File: rtl/hazard_stall_controller.sv
// Pipeline enable/flush sequencing for load-use stalls, redirects and data-memory waits.
// Define HAZARD_PERF_COUNTERS_EN to build the saturating performance counters.
module hazard_stall_controller #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 15,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] idRs1,
  input  logic [REG_ADDR_WIDTH-1:0] idRs2,
  input  logic                      idUsesRs1,
  input  logic                      idUsesRs2,
  input  logic [REG_ADDR_WIDTH-1:0] exRd,
  input  logic                      exMemoryReadEnable,
  input  logic                      exPcUpdateTaken,
  input  logic                      memRequest,
  input  logic                      memReady,
  output logic                      pcWriteEnable,
  output logic                      pcSelectTarget,
  output logic                      ifIdWriteEnable,
  output logic                      ifIdFlush,
  output logic                      idExWriteEnable,
  output logic                      idExFlush,
  output logic                      exMemWriteEnable,
  output logic                      memWbFlush,
  output logic                      memTimeout,
  output logic [COUNT_WIDTH-1:0]    loadUseCount,
  output logic [COUNT_WIDTH-1:0]    redirectCount,
  output logic [COUNT_WIDTH-1:0]    memWaitCount
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;

  logic mem_stall, timeout_hit, freeze, redirect, load_use;
  logic rs1_hit, rs2_hit;

  // A timed-out wait releases exactly like memReady would.
  assign mem_stall   = memRequest && !memReady;
  assign timeout_hit = (state_reg == MEM_WAIT) && mem_stall && (wait_cnt_reg == TIMEOUT_VAL);
  assign freeze      = mem_stall && !timeout_hit;
  assign redirect    = exPcUpdateTaken && !freeze;
  assign rs1_hit     = idUsesRs1 && (idRs1 == exRd);
  assign rs2_hit     = idUsesRs2 && (idRs2 == exRd);
  assign load_use    = exMemoryReadEnable && (exRd != '0) && (rs1_hit || rs2_hit)
                       && !freeze && !redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    pcWriteEnable    = 1'b1;
    pcSelectTarget   = 1'b0;
    ifIdWriteEnable  = 1'b1;
    ifIdFlush        = 1'b0;
    idExWriteEnable  = 1'b1;
    idExFlush        = 1'b0;
    exMemWriteEnable = 1'b1;
    memWbFlush       = 1'b0;
    memTimeout       = timeout_hit;

    case (state_reg)
      RUN: begin
        if (freeze) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (freeze) begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end else begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase

    if (freeze) begin
      pcWriteEnable    = 1'b0;
      ifIdWriteEnable  = 1'b0;
      idExWriteEnable  = 1'b0;
      exMemWriteEnable = 1'b0;
      memWbFlush       = 1'b1;
    end else if (redirect) begin
      pcSelectTarget = 1'b1;
      ifIdFlush      = 1'b1;
      idExFlush      = 1'b1;
    end else if (load_use) begin
      pcWriteEnable   = 1'b0;
      ifIdWriteEnable = 1'b0;
      idExFlush       = 1'b1;
    end

    // While reset is held every stage is parked on a bubble.
    if (!rst_n) begin
      pcWriteEnable    = 1'b0;
      pcSelectTarget   = 1'b0;
      ifIdWriteEnable  = 1'b0;
      ifIdFlush        = 1'b1;
      idExWriteEnable  = 1'b0;
      idExFlush        = 1'b1;
      exMemWriteEnable = 1'b0;
      memWbFlush       = 1'b1;
      memTimeout       = 1'b0;
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [2:0]             count_evt;
  logic [COUNT_WIDTH-1:0] perf_reg [3];

  assign count_evt = {freeze, redirect, load_use};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          perf_reg[gi] <= '0;
        end else if (count_evt[gi] && (perf_reg[gi] != '1)) begin
          perf_reg[gi] <= perf_reg[gi] + COUNT_WIDTH'(1);
        end
      end
    end
  endgenerate

  assign loadUseCount  = perf_reg[0];
  assign redirectCount = perf_reg[1];
  assign memWaitCount  = perf_reg[2];
`else
  assign loadUseCount  = '0;
  assign redirectCount = '0;
  assign memWaitCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed-vector scoreboard bench for hazard_stall_controller; a negedge monitor
// pops the expected control word and counters pushed by the stimulus process.
module tb_hazard_stall_controller;

  localparam int AW = 5;
  localparam int CW = 32;
`ifdef HAZARD_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] idRs1 = '0, idRs2 = '0, exRd = '0;
  logic idUsesRs1 = 1'b0, idUsesRs2 = 1'b0, exMemoryReadEnable = 1'b0;
  logic exPcUpdateTaken = 1'b0, memRequest = 1'b0, memReady = 1'b0;
  logic pcWriteEnable, pcSelectTarget, ifIdWriteEnable, ifIdFlush;
  logic idExWriteEnable, idExFlush, exMemWriteEnable, memWbFlush, memTimeout;
  logic [CW-1:0] loadUseCount, redirectCount, memWaitCount;

  hazard_stall_controller #(.REG_ADDR_WIDTH(AW), .MEM_TIMEOUT(15), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
    .exRd(exRd), .exMemoryReadEnable(exMemoryReadEnable), .exPcUpdateTaken(exPcUpdateTaken),
    .memRequest(memRequest), .memReady(memReady),
    .pcWriteEnable(pcWriteEnable), .pcSelectTarget(pcSelectTarget),
    .ifIdWriteEnable(ifIdWriteEnable), .ifIdFlush(ifIdFlush),
    .idExWriteEnable(idExWriteEnable), .idExFlush(idExFlush),
    .exMemWriteEnable(exMemWriteEnable), .memWbFlush(memWbFlush), .memTimeout(memTimeout),
    .loadUseCount(loadUseCount), .redirectCount(redirectCount), .memWaitCount(memWaitCount)
  );

  always #5 clk = ~clk;

  typedef enum {K_RUN, K_LU, K_RD, K_FRZ, K_TO, K_RST} kind_e;

  typedef struct {
    string         name;
    logic [8:0]    ctl;
    logic [CW-1:0] lu, rd, mw;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   lu_n = 0, rd_n = 0, mw_n = 0;

  // {pcWE, pcSel, ifIdWE, ifIdFlush, idExWE, idExFlush, exMemWE, memWbFlush, memTimeout}
  function automatic logic [8:0] ctl_of(kind_e k);
    case (k)
      K_RUN:   return 9'b1_0_1_0_1_0_1_0_0;
      K_LU:    return 9'b0_0_0_0_1_1_1_0_0;
      K_RD:    return 9'b1_1_1_1_1_1_1_0_0;
      K_FRZ:   return 9'b0_0_0_0_0_0_0_1_0;
      K_TO:    return 9'b1_0_1_0_1_0_1_0_1;
      default: return 9'b0_0_0_1_0_1_0_1_0;
    endcase
  endfunction

  function automatic logic [CW-1:0] cnt(int n);
    return PERF ? CW'(n) : '0;
  endfunction

  task automatic apply(input string name, input kind_e k, input logic rst,
                       input logic [AW-1:0] rs1, input logic u1,
                       input logic [AW-1:0] rs2, input logic u2,
                       input logic [AW-1:0] rd, input logic ld, input logic tk,
                       input logic rq, input logic rdy);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; idRs1 = rs1; idUsesRs1 = u1; idRs2 = rs2; idUsesRs2 = u2;
    exRd = rd; exMemoryReadEnable = ld; exPcUpdateTaken = tk;
    memRequest = rq; memReady = rdy;
    if (k == K_RST) begin
      lu_n = 0; rd_n = 0; mw_n = 0;
    end
    e.name = name; e.ctl = ctl_of(k);
    e.lu = cnt(lu_n); e.rd = cnt(rd_n); e.mw = cnt(mw_n);
    exp_q.push_back(e);
    // Counters are registered, so this cycle's event shows up one cycle later.
    case (k)
      K_LU:    lu_n++;
      K_RD:    rd_n++;
      K_FRZ:   mw_n++;
      default: ;
    endcase
  endtask

  task automatic idle(input string name);
    apply(name, K_RUN, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic timeout_run(input string tag);
    for (int i = 0; i < 15; i++)
      apply({tag, "_frz"}, K_FRZ, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply({tag, "_pulse"}, K_TO, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {pcWriteEnable, pcSelectTarget, ifIdWriteEnable, ifIdFlush, idExWriteEnable,
               idExFlush, exMemWriteEnable, memWbFlush, memTimeout};
        vectors++;
        if (act !== e.ctl || loadUseCount !== e.lu || redirectCount !== e.rd ||
            memWaitCount !== e.mw) begin
          miscompares++;
          $display("FAIL %s: ctl=%b lu=%0d rd=%0d mw=%0d, required ctl=%b lu=%0d rd=%0d mw=%0d",
                   e.name, act, loadUseCount, redirectCount, memWaitCount,
                   e.ctl, e.lu, e.rd, e.mw);
        end else begin
          $display("vector %s ok ctl=%b lu=%0d rd=%0d mw=%0d", e.name, act,
                   loadUseCount, redirectCount, memWaitCount);
        end
      end
    end
  end

  initial begin : stimulus
    apply("reset0", K_RST, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply("reset1", K_RST, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("idle0");

    // Load-use on rs2, then the load has moved on to MEM.
    apply("lu_rs2", K_LU, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    apply("lu_clear", K_RUN, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    apply("lu_rs1", K_LU, 1'b1, 5'd9, 1'b1, 5'd2, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    apply("x0_no_stall", K_RUN, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply("unused_rs1", K_RUN, 1'b1, 5'd7, 1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    apply("branch_wins", K_RD, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle("idle1");

    // Three frozen cycles, release on the fourth.
    for (int i = 0; i < 3; i++)
      apply("mem_wait", K_FRZ, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply("mem_release", K_RUN, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle("idle2");

    // Redirect and hazard held under a freeze, redirect fires on release.
    apply("frz_over_rd", K_FRZ, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    apply("rd_on_release", K_RD, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1);
    idle("idle3");

    timeout_run("to_a");
    apply("refreeze_run", K_FRZ, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply("req_drop", K_RUN, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("idle4");

    // Reset asserted in the second MEM_WAIT cycle.
    apply("rw_enter", K_FRZ, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply("rw_wait1", K_FRZ, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply("rw_reset", K_RST, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply("rw_reset2", K_RST, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply("rw_after", K_RUN, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    timeout_run("to_b");
    apply("final_drop", K_RUN, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("idle5");

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
